pes_vm_ctrl: RTL and testbench
==============================

PES_VM_CTRL -- requirements
Module: pes_vm_ctrl

Interface
REQ-001 Parameter PRICE, default 3, is the product price in coin units (1..6).
REQ-002 Parameter MAX_CREDIT, default 7, is the maximum credit held, and fits in a 3-bit credit register.
REQ-003 Parameter TIMEOUT, default 15, is the number of idle cycles in COLLECT before an automatic refund (1..15).
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 coin_valid  in  1  coin present on coin_val.
REQ-007 coin_val  in  2  coin encoding: 01 = 1 unit, 10 = 2 units, 00/11 = invalid.
REQ-008 coin_ready  out  1  controller can accept a coin this cycle.
REQ-009 cancel  in  1  customer cancel request.
REQ-010 vend_valid  out  1  dispense request to the product mechanism.
REQ-011 vend_ack  in  1  product dispensed.
REQ-012 chg_valid  out  1  request to return one 1-unit coin.
REQ-013 chg_ack  in  1  one unit of change returned.
REQ-014 credit  out  3  current credit register value.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, COLLECT, VEND and CHANGE.
REQ-017 A coin is accepted when coin_valid, coin_ready and a valid coin_val are all high; credit increases by the coin value on the following edge.
REQ-018 Invalid coin_val (00/11) with coin_valid SHALL be ignored: no credit change and no timer reset.
REQ-019 coin_ready SHALL be high only in IDLE or COLLECT, with credit < PRICE and credit <= MAX_CREDIT-2.
REQ-020 IDLE -> COLLECT when a coin is accepted.
REQ-021 COLLECT -> VEND on the cycle after registered credit >= PRICE.
REQ-022 COLLECT -> CHANGE when cancel is high, or when the idle timer reaches TIMEOUT.
  - The idle timer SHALL reset to 0 on each accepted coin.
REQ-023 Cancel and coin in the same cycle: the coin SHALL be accepted, then all credit refunded, with the transition to CHANGE on the next edge.
REQ-024 Cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-025 In VEND, vend_valid SHALL be held high until vend_ack; vend_valid is Moore (registered state only).
REQ-026 On vend_ack in VEND, credit -= PRICE; next state is CHANGE if the remainder > 0, else IDLE.
REQ-027 In CHANGE, chg_valid SHALL be high while credit > 0; each chg_ack decrements credit by 1.
  - CHANGE -> IDLE on the edge where credit becomes 0.
REQ-028 vend_ack outside VEND and chg_ack outside CHANGE SHALL be ignored.
REQ-029 Credit SHALL never exceed MAX_CREDIT nor underflow below 0.
REQ-030 Latency: coin accepted at edge N -> credit updated at N+1 -> VEND entered at N+2 if the price is reached.

Reset
REQ-031 While reset is high at an edge, the block SHALL go to IDLE with credit = 0 and the timer = 0.
REQ-032 Reset values: coin_ready = 1, vend_valid = 0, chg_valid = 0, busy = 0, credit = 0.
REQ-033 Reset mid-VEND or mid-CHANGE SHALL discard the outstanding credit; no refund follows.

Structure
REQ-034 The state encoding, coin encoding constants and the default PRICE/MAX_CREDIT/TIMEOUT values SHALL live in a shared package, pes_vm_pkg.
REQ-035 The idle timer SHALL be one sub-module, pes_vm_timeout: a 4-bit counter with clear, enable and expired outputs.
REQ-036 Next-state logic, output logic and the credit/timer registers SHALL be kept separate; all outputs are glitch-free registered-state decodes.

Verification
REQ-037 The bench SHALL cover at least these scenarios:
  - Coins 01 then 10 (PRICE = 3) -> credit 1 then 3; vend_valid high 2 cycles after the second coin; vend_ack -> IDLE with credit 0 and no chg_valid.
  - Coins 10, 10 -> credit 4; vend_ack -> credit 1; chg_valid high; one chg_ack -> credit 0, IDLE.
  - Coin 01, then no activity for 15 cycles -> CHANGE; chg_valid high; one chg_ack -> IDLE.
  - Coin 10 and cancel in the same cycle with credit 1 -> credit 3, CHANGE; three chg_acks required before IDLE; no vend_valid.
  - Invalid coin_val 11 with coin_valid in IDLE -> credit stays 0, busy stays 0.
  - Reset asserted in VEND with credit 4 -> next cycle IDLE, credit 0, vend_valid 0, chg_valid 0.

Source files
------------

// File: rtl/pes_vm_pkg.sv
// pes_vm_pkg -- shared definitions for the vending-machine controller.
//   state_t      : controller FSM states (IDLE, COLLECT, VEND, CHANGE)
//   COIN_*       : coin_val encodings; anything else is an invalid coin
//   *_DEF        : default PRICE / MAX_CREDIT / TIMEOUT values
//   coin_units() : coin encoding -> credit units (0 for invalid encodings)
//   sat_add()    : credit addition clamped to a ceiling
package pes_vm_pkg;

  localparam int CREDIT_W = 3;
  localparam int TIMER_W  = 4;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [TIMER_W-1:0]  timer_t;

  localparam int PRICE_DEF      = 3;
  localparam int MAX_CREDIT_DEF = 7;
  localparam int TIMEOUT_DEF    = 15;

  localparam logic [1:0] COIN_ONE = 2'b01;
  localparam logic [1:0] COIN_TWO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  function automatic credit_t coin_units(input logic [1:0] code);
    case (code)
      COIN_ONE: coin_units = credit_t'(1);
      COIN_TWO: coin_units = credit_t'(2);
      default:  coin_units = '0;
    endcase
  endfunction

  function automatic credit_t sat_add(input credit_t a, input credit_t b,
                                      input credit_t ceiling);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, ceiling}) sat_add = ceiling;
    else                       sat_add = sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/pes_vm_timeout.sv
// pes_vm_timeout -- idle timer for the COLLECT state.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : synchronous clear (wins over enable)
//   enable  : count one idle cycle
//   expired : count has reached TIMEOUT; the count holds there until cleared
module pes_vm_timeout
  import pes_vm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam timer_t LIMIT = timer_t'(TIMEOUT);

  timer_t count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset || clear)            count_q <= '0;
    else if (enable && !expired)   count_q <= count_q + timer_t'(1);
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/pes_vm_ctrl.sv
// pes_vm_ctrl -- coin-operated vending controller.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   coin_valid/coin_val   : coin offer (01 = 1 unit, 10 = 2 units)
//   coin_ready            : a coin offered this cycle will be accepted
//   cancel                : refund request, honoured only while collecting
//   vend_valid/vend_ack   : dispense handshake
//   chg_valid/chg_ack     : one-unit change handshake
//   credit                : current credit
//   busy                  : controller is not IDLE
// All outputs decode registered state only.
module pes_vm_ctrl
  import pes_vm_pkg::*;
#(
  parameter int PRICE      = PRICE_DEF,
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  output logic                coin_ready,
  input  logic                cancel,
  output logic                vend_valid,
  input  logic                vend_ack,
  output logic                chg_valid,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam credit_t PRICE_U   = credit_t'(PRICE);
  localparam credit_t MAX_U     = credit_t'(MAX_CREDIT);
  localparam credit_t ACCEPT_LIM = credit_t'(MAX_CREDIT - 2);

  state_t  state_q, state_d;
  credit_t credit_q, credit_d;
  credit_t remainder;
  logic    coin_ok, coin_acc;
  logic    timer_clear, timer_en, timer_expired;

  // ---------------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------------
  assign coin_ok   = coin_valid && (coin_val == COIN_ONE || coin_val == COIN_TWO);
  assign coin_acc  = coin_ok && coin_ready;
  // Only meaningful in VEND, where credit >= PRICE; guarded against underflow.
  assign remainder = (credit_q >= PRICE_U) ? credit_q - PRICE_U : '0;

  // The timer counts only while collecting; invalid coins do not restart it.
  assign timer_clear = (state_q != ST_COLLECT) || coin_acc;
  assign timer_en    = (state_q == ST_COLLECT);

  pes_vm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_acc) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // A coin arriving with cancel is still credited, then refunded in full.
        if (cancel)                            state_d = ST_CHANGE;
        else if (credit_q >= PRICE_U)          state_d = ST_VEND;
        else if (timer_expired && !coin_acc)   state_d = ST_CHANGE;
      end
      ST_VEND: begin
        if (vend_ack) state_d = (remainder != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (credit_q == '0)                                 state_d = ST_IDLE;
        else if (chg_ack && credit_q == credit_t'(1))       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit next value
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (coin_acc) credit_d = sat_add(credit_q, coin_units(coin_val), MAX_U);
      end
      ST_VEND: begin
        if (vend_ack) credit_d = remainder;
      end
      ST_CHANGE: begin
        if (chg_ack && credit_q != '0) credit_d = credit_q - credit_t'(1);
      end
      default: credit_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and credit registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decodes of registered state and credit only
  // ---------------------------------------------------------------------------
  always_comb begin
    coin_ready = (state_q == ST_IDLE || state_q == ST_COLLECT) &&
                 (credit_q < PRICE_U) && (credit_q <= ACCEPT_LIM);
    vend_valid = (state_q == ST_VEND);
    chg_valid  = (state_q == ST_CHANGE) && (credit_q != '0);
    busy       = (state_q != ST_IDLE);
    credit     = credit_q;
  end

endmodule

// File: tb/tb_pes_vm_ctrl.sv
// tb_pes_vm_ctrl -- directed bench for pes_vm_ctrl with default parameters
// (PRICE 3, MAX_CREDIT 7, TIMEOUT 15). Inputs change on the falling edge;
// outputs are sampled 1 time unit after the rising edge.
module tb_pes_vm_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       coin_ready;
  logic       cancel;
  logic       vend_valid;
  logic       vend_ack;
  logic       chg_valid;
  logic       chg_ack;
  logic [2:0] credit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  pes_vm_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .coin_ready (coin_ready),
    .cancel     (cancel),
    .vend_valid (vend_valid),
    .vend_ack   (vend_ack),
    .chg_valid  (chg_valid),
    .chg_ack    (chg_ack),
    .credit     (credit),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       cvalid;
    logic [1:0] cval;
    logic       cncl;
    logic       vack;
    logic       cack;
    logic [2:0] exp_credit;
    logic       exp_ready;
    logic       exp_vend;
    logic       exp_chg;
    logic       exp_busy;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs, then sample the outputs.
  task automatic cycle(input logic rst, input logic cv, input logic [1:0] val,
                       input logic cn, input logic va, input logic ca);
    @(negedge clock);
    reset = rst; coin_valid = cv; coin_val = val;
    cancel = cn; vend_ack = va; chg_ack = ca;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cr, input int rdy,
                            input int vv, input int cv, input int bsy);
    check({tag, " credit"},     int'(credit),     cr);
    check({tag, " coin_ready"}, int'(coin_ready), rdy);
    check({tag, " vend_valid"}, int'(vend_valid), vv);
    check({tag, " chg_valid"},  int'(chg_valid),  cv);
    check({tag, " busy"},       int'(busy),       bsy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_val = 2'b00;
    cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;

    //           rst cv val    cn va ca | credit rdy vv cv busy
    tbl[0]  = '{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0}; // reset
    tbl[1]  = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,2'b11,1'b0,1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0}; // invalid 11
    tbl[3]  = '{1'b0,1'b1,2'b00,1'b0,1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0}; // invalid 00
    tbl[4]  = '{1'b0,1'b1,2'b01,1'b0,1'b0,1'b0, 3'd1,1'b1,1'b0,1'b0,1'b1}; // coin 1
    tbl[5]  = '{1'b0,1'b1,2'b10,1'b0,1'b0,1'b0, 3'd3,1'b0,1'b0,1'b0,1'b1}; // coin 2
    tbl[6]  = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 3'd3,1'b0,1'b1,1'b0,1'b1}; // VEND
    tbl[7]  = '{1'b0,1'b0,2'b00,1'b1,1'b0,1'b1, 3'd3,1'b0,1'b1,1'b0,1'b1}; // cancel/chg_ack ignored
    tbl[8]  = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 3'd3,1'b0,1'b1,1'b0,1'b1}; // held
    tbl[9]  = '{1'b0,1'b0,2'b00,1'b0,1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0}; // vend_ack -> IDLE
    tbl[10] = '{1'b0,1'b0,2'b00,1'b0,1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0}; // stray vend_ack
    tbl[11] = '{1'b0,1'b1,2'b10,1'b0,1'b0,1'b0, 3'd2,1'b1,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b0,1'b1,2'b10,1'b0,1'b0,1'b0, 3'd4,1'b0,1'b0,1'b0,1'b1};
    tbl[13] = '{1'b0,1'b1,2'b01,1'b0,1'b0,1'b0, 3'd4,1'b0,1'b1,1'b0,1'b1}; // not ready
    tbl[14] = '{1'b0,1'b0,2'b00,1'b0,1'b1,1'b0, 3'd1,1'b0,1'b0,1'b1,1'b1}; // -> CHANGE
    tbl[15] = '{1'b0,1'b0,2'b00,1'b1,1'b1,1'b0, 3'd1,1'b0,1'b0,1'b1,1'b1}; // ignored
    tbl[16] = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b1, 3'd0,1'b1,1'b0,1'b0,1'b0}; // chg_ack -> IDLE
    tbl[17] = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b1, 3'd0,1'b1,1'b0,1'b0,1'b0}; // stray chg_ack
    tbl[18] = '{1'b0,1'b1,2'b01,1'b0,1'b0,1'b0, 3'd1,1'b1,1'b0,1'b0,1'b1};
    tbl[19] = '{1'b0,1'b1,2'b01,1'b0,1'b0,1'b0, 3'd2,1'b1,1'b0,1'b0,1'b1};
    tbl[20] = '{1'b0,1'b1,2'b01,1'b0,1'b0,1'b0, 3'd3,1'b0,1'b0,1'b0,1'b1};
    tbl[21] = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 3'd3,1'b0,1'b1,1'b0,1'b1};
    tbl[22] = '{1'b0,1'b0,2'b00,1'b0,1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0};
    tbl[23] = '{1'b0,1'b1,2'b01,1'b1,1'b0,1'b0, 3'd1,1'b1,1'b0,1'b0,1'b1}; // cancel in IDLE
    tbl[24] = '{1'b0,1'b0,2'b00,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,1'b1,1'b1}; // cancel -> CHANGE
    tbl[25] = '{1'b0,1'b0,2'b00,1'b0,1'b0,1'b1, 3'd0,1'b1,1'b0,1'b0,1'b0};

    for (int i = 0; i < NVEC; i++) begin
      cycle(tbl[i].rst, tbl[i].cvalid, tbl[i].cval, tbl[i].cncl,
            tbl[i].vack, tbl[i].cack);
      expect_out($sformatf("vec%0d", i), int'(tbl[i].exp_credit),
                 int'(tbl[i].exp_ready), int'(tbl[i].exp_vend),
                 int'(tbl[i].exp_chg), int'(tbl[i].exp_busy));
    end

    // Timeout: one coin, then 15 quiet cycles stay in COLLECT, the 16th refunds.
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_out("to_coin", 1, 1, 0, 0, 1);
    idle(15);
    expect_out("to_wait15", 1, 1, 0, 0, 1);
    idle(1);
    expect_out("to_change", 1, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("to_idle", 0, 1, 0, 0, 0);

    // A second coin restarts the idle timer.
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(10);
    expect_out("tr_wait10", 1, 1, 0, 0, 1);
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(15);
    expect_out("tr_wait15", 2, 1, 0, 0, 1);
    idle(1);
    expect_out("tr_change", 2, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("tr_ack1", 1, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("tr_idle", 0, 1, 0, 0, 0);

    // Coin and cancel together: coin credited, all three units refunded.
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_out("cc_coin1", 1, 1, 0, 0, 1);
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    expect_out("cc_change", 3, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("cc_ack1", 2, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("cc_ack2", 1, 0, 0, 1, 1);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_out("cc_ack3", 0, 1, 0, 0, 0);

    // Reset in VEND with credit 4 discards the credit, no refund follows.
    cycle(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1);
    expect_out("rv_vend", 4, 0, 1, 0, 1);
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_out("rv_reset", 0, 1, 0, 0, 0);
    idle(2);
    expect_out("rv_after", 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
